cs_ctrl: RTL and testbench
==========================

CS_CTRL -- requirements
Module: cs_ctrl

Interface
REQ-001 SHALL have parameter N, default 9: samples per window; valid outputs begin once N samples are held.
REQ-002 SHALL have parameter LAT, default 1: cycles from dp_shift to dp_y valid, range 1..7.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  frame-start pulse; clears window and restarts fill.
REQ-006 SHALL have port in_valid  input  1  sample offered.
REQ-007 SHALL have port in_ready  output  1  controller accepts sample this cycle.
REQ-008 SHALL have port in_data  input  8  unsigned sample.
REQ-009 SHALL have port dp_clr  output  1  one-cycle clear of datapath window registers.
REQ-010 SHALL have port dp_shift  output  1  one-cycle shift strobe into datapath window.
REQ-011 SHALL have port dp_x  output  8  sample driven to datapath, valid with dp_shift.
REQ-012 SHALL have port dp_y  input  10  datapath smoothed result.
REQ-013 SHALL have port out_valid  output  1  out_data holds a result.
REQ-014 SHALL have port out_ready  input  1  downstream consumes result.
REQ-015 SHALL have port out_data  output  10  registered result.
REQ-016 SHALL have port fill_cnt  output  4  samples in window, saturating at N.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE and ACCEPT.

Function
REQ-018 SHALL implement states IDLE, CLR, ACCEPT, WAIT, OUT.
REQ-019 IDLE: in_ready=0; start -> CLR.
REQ-020 CLR: dp_clr=1 for exactly one cycle, fill_cnt<=0, lat counter<=0; next ACCEPT.
REQ-021 ACCEPT: in_ready=1; in_valid&in_ready -> dp_shift=1, dp_x=in_data same cycle, fill_cnt<=min(fill_cnt+1,N), lat counter<=LAT, next WAIT.
REQ-022 WAIT: in_ready=0; lat counter decrements per cycle; at 0, capture dp_y into out_data and go OUT if fill_cnt==N, else go ACCEPT with no capture.
REQ-023 OUT: out_valid=1, out_data stable, in_ready=0 until out_ready=1; on the out_ready cycle, next ACCEPT and out_valid low the following cycle.
REQ-024 Throughput SHALL be one sample per LAT+2 cycles with out_ready tied high; no combinational path from in_valid or out_ready to in_ready.
REQ-025 start in any state other than IDLE SHALL abort: out_valid<=0, any pending result dropped, next CLR.
REQ-026 start coincident with in_valid in ACCEPT: start wins, no dp_shift, sample not accepted.
REQ-027 fill_cnt SHALL saturate at N; no wrap for unbounded streams.
REQ-028 dp_shift and dp_clr SHALL never be high in the same cycle.

Reset
REQ-029 reset low SHALL immediately force IDLE, in_ready=0, dp_clr=0, dp_shift=0, dp_x=0, out_valid=0, out_data=0, fill_cnt=0, busy=0, lat counter=0.
REQ-030 reset asserted mid-WAIT or mid-OUT SHALL discard the pending result; after release, the first start is required before any sample is accepted.

Configuration
REQ-031 Macro CS_CTRL_FILL_OUT_EN defined: WAIT SHALL go to OUT on every sample, including while fill_cnt<N (partial-window results emitted; fill_cnt qualifies them).
REQ-032 Macro CS_CTRL_FILL_OUT_EN undefined: results SHALL be emitted only when fill_cnt==N (REQ-022).

Structure
REQ-033 Shared package SHALL hold the state encoding (3-bit), default N, default LAT, sample width 8, result width 10.
REQ-034 One sub-module, cs_ctrl_latcnt (loadable down-counter, done flag), SHALL implement the WAIT latency counter; the FSM stays in cs_ctrl.

Verification
REQ-035 start, then 9 samples of 100 with the datapath attached, out_ready=1 -> samples 1-8 give no out_valid; after sample 9, out_valid=1 with out_data=225.
REQ-036 Steady state, out_ready=0 for 5 cycles -> out_valid held, out_data unchanged, in_ready=0, no dp_shift; out_ready=1 -> ACCEPT next cycle.
REQ-037 start asserted during OUT after 12 samples -> out_valid drops, dp_clr pulses once, fill_cnt=0; next 8 samples give no output.
REQ-038 reset low during WAIT -> all outputs zero asynchronously; in_valid ignored until start.
REQ-039 start and in_valid high together in ACCEPT -> no dp_shift, fill_cnt=0, state CLR.
REQ-040 CS_CTRL_FILL_OUT_EN defined, 3 samples after start -> 3 results with fill_cnt 1, 2, 3.

Source files
------------

// File: rtl/cs_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cs_ctrl_pkg
// Shared definitions for the smoothing-window controller: FSM state encoding,
// default window length and datapath latency, and the sample/result widths.
// No ports (package).
// ---------------------------------------------------------------------------
package cs_ctrl_pkg;

  localparam int N_DEF   = 9;   // samples per window
  localparam int LAT_DEF = 1;   // dp_shift -> dp_y latency in cycles
  localparam int DATA_W  = 8;   // sample width
  localparam int RES_W   = 10;  // smoothed result width
  localparam int FILL_W  = 4;   // fill counter width (N up to 15)
  localparam int LAT_W   = 3;   // latency counter width (LAT up to 7)

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_ACCEPT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  // Increment that sticks at lim so long streams never wrap the fill count.
  function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] cnt,
                                                input logic [FILL_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/cs_ctrl_if.sv
// ---------------------------------------------------------------------------
// cs_ctrl_if
// Sample-in / result-out handshake bundle of the controller.
//   in_valid  : upstream offers in_data
//   in_ready  : controller accepts the sample this cycle
//   in_data   : unsigned sample
//   out_valid : out_data holds a result
//   out_ready : downstream consumes the result
//   out_data  : registered smoothed result
// Modports: master = upstream/downstream side, slave = the controller.
// ---------------------------------------------------------------------------
interface cs_ctrl_if;
  import cs_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/cs_ctrl_latcnt.sv
// ---------------------------------------------------------------------------
// cs_ctrl_latcnt
// Loadable down-counter timing the wait for the datapath result.
//   clk   : clock
//   reset : asynchronous active-low reset
//   clr   : force count to zero
//   load  : load load_val (ignored when clr is high)
//   load_val : latency value to load
//   dec   : decrement this cycle (holds at zero)
//   done  : the current WAIT cycle is the last one (count is 1 or 0), i.e. a
//           decrement now brings the count to zero
// ---------------------------------------------------------------------------
module cs_ctrl_latcnt
  import cs_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Signalling one cycle early lets the FSM capture dp_y on the very cycle
  // the count reaches zero instead of spending an extra cycle at zero.
  assign done = (count <= LAT_W'(1));

endmodule

// File: rtl/cs_ctrl.sv
// ---------------------------------------------------------------------------
// cs_ctrl
// Control FSM for a sliding-window smoothing datapath. Accepts one sample at
// a time, strobes it into the datapath, waits LAT cycles for the smoothed
// value and presents it on the output handshake once the window is full.
//
// Parameters: N   - samples per window (1..15)
//             LAT - cycles from dp_shift to dp_y valid (1..7)
// Ports:
//   clk      : single clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : frame start; clears the window and restarts the fill
//   bus      : cs_ctrl_if.slave (in_valid/in_ready/in_data,
//              out_valid/out_ready/out_data)
//   dp_clr   : one-cycle clear of the datapath window
//   dp_shift : one-cycle shift strobe into the datapath window
//   dp_x     : sample to the datapath, valid with dp_shift
//   dp_y     : smoothed result from the datapath
//   fill_cnt : samples held in the window, saturating at N
//   busy     : high in every state except IDLE and ACCEPT
//
// Build option: define CS_CTRL_FILL_OUT_EN to emit a result for every sample,
// including partial windows (fill_cnt qualifies them). Undefined, results
// appear only once the window is full.
// ---------------------------------------------------------------------------
module cs_ctrl
  import cs_ctrl_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LAT = LAT_DEF
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  cs_ctrl_if.slave          bus,
  output logic              dp_clr,
  output logic              dp_shift,
  output logic [DATA_W-1:0] dp_x,
  input  logic [RES_W-1:0]  dp_y,
  output logic [FILL_W-1:0] fill_cnt,
  output logic              busy
);

  localparam logic [FILL_W-1:0] N_FILL = FILL_W'(N);
  localparam logic [LAT_W-1:0]  LAT_LD = LAT_W'(LAT);

  state_t            state, state_nxt;
  logic              shift, capture;
  logic              fill_clr, fill_inc;
  logic              cnt_clr, cnt_load, cnt_dec, cnt_done;
  logic [FILL_W-1:0] fill_q;
  logic [RES_W-1:0]  out_q;

  cs_ctrl_latcnt u_latcnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (LAT_LD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    capture   = 1'b0;
    fill_clr  = 1'b0;
    fill_inc  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    if (start) begin
      // start overrides everything, including a sample offered in the same
      // cycle; the fill count drops immediately so the abort is visible in CLR.
      state_nxt = ST_CLR;
      fill_clr  = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_CLR: begin
          fill_clr  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            shift     = 1'b1;
            fill_inc  = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_dec = 1'b1;
          if (cnt_done) begin
`ifdef CS_CTRL_FILL_OUT_EN
            capture   = 1'b1;
            state_nxt = ST_OUT;
`else
            if (fill_q == N_FILL) begin
              capture   = 1'b1;
              state_nxt = ST_OUT;
            end else begin
              state_nxt = ST_ACCEPT;
            end
`endif
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state_nxt = ST_ACCEPT;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      fill_q <= '0;
    end else begin
      state <= state_nxt;
      if (fill_clr) begin
        fill_q <= '0;
      end else if (fill_inc) begin
        fill_q <= sat_inc(fill_q, N_FILL);
      end
    end
  end

  // Result register; cleared on reset so a pending result never survives it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else if (capture) begin
      out_q <= dp_y;
    end
  end

  // All handshake outputs decode from registered state (plus start), so
  // in_valid and out_ready never reach in_ready combinationally.
  assign bus.in_ready  = (state == ST_ACCEPT) && !start;
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_data  = out_q;
  assign dp_clr        = (state == ST_CLR);
  assign dp_shift      = shift;
  assign dp_x          = shift ? bus.in_data : '0;
  assign fill_cnt      = fill_q;
  assign busy          = !((state == ST_IDLE) || (state == ST_ACCEPT));

endmodule

// File: tb/tb_cs_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cs_ctrl
// Self-checking bench for cs_ctrl with a 9-tap sum/4 smoothing datapath
// (combinational from its window registers, so LAT=1 matches it).
// ---------------------------------------------------------------------------
module tb_cs_ctrl;
  import cs_ctrl_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic              dp_clr;
  logic              dp_shift;
  logic [DATA_W-1:0] dp_x;
  logic [RES_W-1:0]  dp_y;
  logic [FILL_W-1:0] fill_cnt;
  logic              busy;

  cs_ctrl_if bus ();

  cs_ctrl #(.N(9), .LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .dp_clr   (dp_clr),
    .dp_shift (dp_shift),
    .dp_x     (dp_x),
    .dp_y     (dp_y),
    .fill_cnt (fill_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: 9-sample window, result = sum >> 2
  logic [7:0]  win [9];
  logic [11:0] win_sum;

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 9; i++) win[i] <= 8'd0;
    end else if (dp_shift) begin
      for (int i = 8; i > 0; i--) win[i] <= win[i-1];
      win[0] <= dp_x;
    end
  end

  always_comb begin
    win_sum = 12'd0;
    for (int i = 0; i < 9; i++) win_sum = win_sum + 12'(win[i]);
    dp_y = 10'(win_sum >> 2);
  end

  typedef struct {
    logic       start;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_clr;
    logic       e_sh;
    logic       e_ov;
    logic [9:0] e_od;
    logic [3:0] e_fill;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic void add(input logic s, input logic iv, input int din,
                              input logic ordy, input logic ir, input logic clr,
                              input logic sh, input logic ov, input int od,
                              input int fill, input logic bsy);
    vec_t v;
    v.start  = s;
    v.iv     = iv;
    v.din    = 8'(din);
    v.ordy   = ordy;
    v.e_ir   = ir;
    v.e_clr  = clr;
    v.e_sh   = sh;
    v.e_ov   = ov;
    v.e_od   = 10'(od);
    v.e_fill = 4'(fill);
    v.e_busy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic iv, input int din, input logic ordy);
    start        = s;
    bus.in_valid = iv;
    bus.in_data  = 8'(din);
    bus.out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"},  int'(bus.in_ready), 0);
    chk({tag, " dp_clr"},    int'(dp_clr), 0);
    chk({tag, " dp_shift"},  int'(dp_shift), 0);
    chk({tag, " dp_x"},      int'(dp_x), 0);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " out_data"},  int'(bus.out_data), 0);
    chk({tag, " fill_cnt"},  int'(fill_cnt), 0);
    chk({tag, " busy"},      int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(0, 0, 0, 0);

    // ---------------- vector table ----------------
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);      // IDLE with start
    add(0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);      // CLR
`ifdef CS_CTRL_FILL_OUT_EN
    for (int k = 1; k <= 3; k++) begin
      add(0, 1, 100, 1, 1, 0, 1, 0, 0, k-1, 0);  // ACCEPT
      add(0, 0, 0, 1,   0, 0, 0, 0, 0, k, 1);    // WAIT
      add(0, 0, 0, 1,   0, 0, 0, 1, 25*k, k, 1); // OUT partial window
    end
`else
    for (int k = 1; k <= 9; k++) begin
      add(0, 1, 100, 1, 1, 0, 1, 0, 0, k-1, 0);  // ACCEPT
      add(0, 0, 0, 1,   0, 0, 0, 0, 0, k, 1);    // WAIT
    end
    add(0, 0, 0, 1,   0, 0, 0, 1, 225, 9, 1);    // OUT: 900>>2
    // sample 10 = 200: window 8*100+200 = 1000 -> 250, downstream stalls 5
    add(0, 1, 200, 1, 1, 0, 1, 0, 0, 9, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 9, 1);
    for (int k = 0; k < 5; k++)
      add(0, 1, 55, 0, 0, 0, 0, 1, 250, 9, 1);   // stalled OUT, in_valid ignored
    add(0, 0, 0, 1,   0, 0, 0, 1, 250, 9, 1);
    // sample 11 = 20: 7*100+200+20 = 920 -> 230
    add(0, 1, 20, 1,  1, 0, 1, 0, 0, 9, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 9, 1);
    add(0, 0, 0, 1,   0, 0, 0, 1, 230, 9, 1);
    // sample 12 = 0: 6*100+200+20+0 = 820 -> 205, start aborts in OUT
    add(0, 1, 0, 1,   1, 0, 1, 0, 0, 9, 0);
    add(0, 0, 0, 1,   0, 0, 0, 0, 0, 9, 1);
    add(1, 0, 0, 0,   0, 0, 0, 1, 205, 9, 1);
    add(0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 1);      // CLR, fill already 0
    for (int k = 1; k <= 9; k++) begin
      add(0, 1, 4, 1, 1, 0, 1, 0, 0, k-1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, k, 1);
    end
    add(0, 0, 0, 1,   0, 0, 0, 1, 9, 9, 1);      // 9*4 = 36 -> 9, clean window
`endif

    // reset state
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #3;
    reset = 1'b1;
    next_cycle();

    // ---------------- table replay ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].iv, int'(vecs[i].din), vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i), int'(bus.in_ready), int'(vecs[i].e_ir));
      chk($sformatf("row%0d dp_clr", i),   int'(dp_clr),       int'(vecs[i].e_clr));
      chk($sformatf("row%0d dp_shift", i), int'(dp_shift),     int'(vecs[i].e_sh));
      chk($sformatf("row%0d out_valid", i), int'(bus.out_valid), int'(vecs[i].e_ov));
      chk($sformatf("row%0d fill_cnt", i), int'(fill_cnt),     int'(vecs[i].e_fill));
      chk($sformatf("row%0d busy", i),     int'(busy),         int'(vecs[i].e_busy));
      if (vecs[i].e_ov)
        chk($sformatf("row%0d out_data", i), int'(bus.out_data), int'(vecs[i].e_od));
      if (vecs[i].e_sh)
        chk($sformatf("row%0d dp_x", i), int'(dp_x), int'(vecs[i].din));
      chk($sformatf("row%0d clr_shift_excl", i), int'(dp_clr & dp_shift), 0);
      next_cycle();
    end

    // ---------------- start with in_valid in ACCEPT ----------------
    drive(1, 1, 50, 1);
    @(negedge clk);
    chk("startacc dp_shift", int'(dp_shift), 0);
    chk("startacc in_ready", int'(bus.in_ready), 0);
    next_cycle();
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("startacc dp_clr", int'(dp_clr), 1);
    chk("startacc fill_cnt", int'(fill_cnt), 0);
    chk("startacc busy", int'(busy), 1);
    chk("startacc dp_shift2", int'(dp_shift), 0);
    next_cycle();

    // ---------------- reset during WAIT ----------------
    drive(0, 1, 77, 1);
    @(negedge clk);
    chk("rstwait dp_shift", int'(dp_shift), 1);
    chk("rstwait dp_x", int'(dp_x), 77);
    next_cycle();
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("rstwait busy_in_wait", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rstwait");
    @(posedge clk);
    #2;
    reset = 1'b1;
    drive(0, 1, 33, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d in_ready", k), int'(bus.in_ready), 0);
      chk($sformatf("postrst%0d dp_shift", k), int'(dp_shift), 0);
      chk($sformatf("postrst%0d fill_cnt", k), int'(fill_cnt), 0);
      next_cycle();
    end
    drive(1, 1, 33, 1);
    @(negedge clk);
    chk("restart dp_shift", int'(dp_shift), 0);
    next_cycle();
    drive(0, 1, 33, 1);
    @(negedge clk);
    chk("restart dp_clr", int'(dp_clr), 1);
    chk("restart dp_shift_clr", int'(dp_shift), 0);
    next_cycle();
    @(negedge clk);
    chk("restart accept dp_shift", int'(dp_shift), 1);
    chk("restart accept dp_x", int'(dp_x), 33);
    chk("restart accept in_ready", int'(bus.in_ready), 1);
    next_cycle();
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("restart wait fill_cnt", int'(fill_cnt), 1);
    chk("restart wait busy", int'(busy), 1);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
